// File: rtl/fpnew_result_fifo.sv
// fpnew_result_fifo
// In-order result buffer placed after an opgroup block. Entries carrying
// {tag, extension bit, status, result} are accepted through a valid/ready
// handshake, stored in a small circular flip-flop FIFO and presented in
// order downstream. Status of every popped entry is OR-ed into sticky
// fflags for the CSR update.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   flush_i               drop all stored entries (fflags kept)
//   in_valid_i/in_ready_o upstream handshake; result_i, status_i,
//                         extension_bit_i, tag_i sampled on push
//   out_valid_o/out_ready_i downstream handshake; result_o, status_o,
//                         extension_bit_o, tag_o show the head entry
//   fflags_o, fflags_clr_i sticky status accumulator and its clear
//   count_o, busy_o       occupancy and non-empty indication
module fpnew_result_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  logic [4:0]                 status_i,
    input  logic                       extension_bit_i,
    input  logic                       tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output logic [4:0]                 status_o,
    output logic                       extension_bit_o,
    output logic                       tag_o,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CntW   = $clog2(Depth+1);
    localparam int unsigned EntryW = Width + 7;

    logic [EntryW-1:0] mem_q [Depth];
    logic [EntryW-1:0] head;
    logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        fflags_q, fflags_d;
    logic              push, pop;

    assign in_ready_o  = (cnt_q != CntW'(Depth));
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // Head fields are forced to zero while empty so outputs read 0 after
    // reset even though the storage array itself is not reset.
    assign head            = mem_q[rptr_q];
    assign result_o        = out_valid_o ? head[Width-1:0]        : '0;
    assign status_o        = out_valid_o ? head[Width+4:Width]    : '0;
    assign extension_bit_o = out_valid_o ? head[Width+5]          : 1'b0;
    assign tag_o           = out_valid_o ? head[Width+6]          : 1'b0;

    assign fflags_o = fflags_q;
    assign count_o  = cnt_q;
    assign busy_o   = out_valid_o;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        fflags_d = fflags_clr_i ? '0 : fflags_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                wptr_d = (wptr_q == PtrW'(Depth-1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_d   = (rptr_q == PtrW'(Depth-1)) ? '0 : rptr_q + PtrW'(1);
                fflags_d = fflags_d | status_o;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            fflags_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            fflags_q <= fflags_d;
        end
    end

    // Storage carries no reset; a write is simply suppressed on reset/flush.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem_q[wptr_q] <= {tag_i, extension_bit_i, status_i, result_i};
        end
    end

endmodule

// File: doc/fpnew_result_fifo.md
Name: fpnew_result_fifo

Overview:
Output buffer that sits directly downstream of each opgroup block. It accepts the arbitrated result, status, extension bit and tag through a valid/ready handshake and stores them in a small circular FIFO. Results are presented in order to the FPU top-level output arbiter. It also keeps sticky per-FIFO exception flags, accumulated from each result as it leaves the FIFO, for CSR fflags update.

Parameters:
Width, 32, result data width in bits; must match the upstream opgroup block.
Depth, 4, number of entries; legal range 2..16; need not be a power of two.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  drop all stored entries
in_valid_i  input  1  upstream result valid
in_ready_o  output  1  FIFO can accept an entry
result_i  input  Width  upstream result
status_i  input  5  upstream status {NV,DZ,OF,UF,NX}
extension_bit_i  input  1  upstream extension bit
tag_i  input  1  upstream tag
out_valid_o  output  1  head entry valid
out_ready_i  input  1  downstream accepts head
result_o  output  Width  head result
status_o  output  5  head status
extension_bit_o  output  1  head extension bit
tag_o  output  1  head tag
fflags_o  output  5  sticky OR of status of every popped entry
fflags_clr_i  input  1  clear fflags_o
count_o  output  $clog2(Depth+1)  current occupancy
busy_o  output  1  count_o != 0

Behaviour:
- Reset (rst_i high at a clock edge), all registered state goes to zero: write pointer, read pointer, count and fflags.
  - After reset: in_ready_o=1, out_valid_o=0, count_o=0, fflags_o=0, busy_o=0.
  - Data outputs are 0 after reset and don't-care whenever out_valid_o=0.
  - rst_i has priority over every other input, including mid-transfer; the entries in flight are lost.
- Push occurs when in_valid_i & in_ready_o. The entry is written at wptr and wptr advances. When wptr reaches Depth-1 it wraps to 0.
- Pop occurs when out_valid_o & out_ready_i. rptr advances with the same wrap rule.
- in_ready_o = (count_o != Depth).
  - It is combinational from registered state only; it never depends on out_ready_i, so there is no pass-through path when full.
- out_valid_o = (count_o != 0).
  - Head data is read combinationally from the storage at rptr.
- Latency: an entry pushed at edge N is visible with out_valid_o=1 in the cycle after edge N. There is no same-cycle fall-through.
- Count update:
  - count increments on push only.
  - count decrements on pop only.
  - count is unchanged on simultaneous push and pop, which is legal whenever 0 < count < Depth.
- Boundary conditions:
  - When full, a push cannot occur; a pop frees the slot, visible next cycle.
  - When empty, a pop cannot occur; out_ready_i is ignored.
- Flush (flush_i=1 at an edge):
  - count, wptr and rptr go to 0.
  - Any push or pop attempted in that cycle is discarded.
  - A pop in that cycle does not update fflags.
  - fflags is not cleared by flush.
  - in_ready_o and out_valid_o follow their normal equations in the flush cycle.
- fflags next state: (fflags_clr_i ? 0 : fflags) | (pop ? status_o : 0).
  - A clear and a pop in the same cycle therefore leave exactly the popped status.
- The upstream handshake contract is honoured: data is sampled only on the push edge. Upstream may change data while in_ready_o=0.
- Storage is flip-flop based, of width Width+7 bits per entry. No reset is required on the storage array.

Test Plan:
- Reset then idle: hold rst_i 2 cycles -> in_ready_o=1, out_valid_o=0, count_o=0, fflags_o=0, busy_o=0.
- Fill and drain, Depth=4, out_ready_i=0:
  - Push results 0x11,0x22,0x33,0x44 -> count_o=4, in_ready_o=0.
  - A 5th push (0x55) is not accepted.
  - Raise out_ready_i -> results pop in order 0x11..0x44, then out_valid_o=0.
- Wrap-around: run 10 pushes and 10 pops interleaved with a random out_ready_i pattern -> outputs match a reference queue, pointer wraps exercised, count_o never exceeds 4.
- Simultaneous push and pop at count=2:
  - count_o stays 2.
  - The new entry appears after the two older ones.
  - The popped entry's status=0x01 -> fflags_o=0x01.
- fflags clear:
  - With fflags_o=0x10, pop status 0x04 while fflags_clr_i=1 -> fflags_o=0x04.
  - Then fflags_clr_i alone -> fflags_o=0.
- Flush and reset mid-operation:
  - With 3 entries, assert flush_i together with in_valid_i and out_ready_i -> next cycle count_o=0, out_valid_o=0, fflags_o unchanged.
  - Repeat the setup with rst_i instead -> all outputs at reset values, fflags_o=0.
